riscv_sb_interconnect: RTL and testbench

Parametrised system-bus interconnect between the LSU memory port and N peripheral slots, replacing the fixed three-slave address decode and read mux in the top-level unit. A registered request/response FSM forwards one transaction at a time to the slot chosen by a configurable address field. It holds the slot request until that slot reports ready, and returns a bus error for unpopulated slots or when a slave exceeds a wait-state timeout.

---
 rtl/riscv_sb_pkg.sv | 19 +
 rtl/riscv_sb_decoder.sv | 35 +++
 rtl/riscv_sb_interconnect.sv | 149 ++++++++++++++
 tb/tb_riscv_sb_interconnect.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_sb_pkg.sv
// Shared types and constants for the system-bus interconnect: FSM states,
// default slot-select field / timeout, and the well-known slot indices.
package riscv_sb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } sb_state_t;

  localparam int SB_SEL_MSB = 31;
  localparam int SB_SEL_LSB = 24;
  localparam int SB_TIMEOUT = 15;

  localparam int SLOT_DMEM = 0;
  localparam int SLOT_PS2  = 3;
  localparam int SLOT_VGA  = 7;

endpackage

// File: rtl/riscv_sb_decoder.sv
// Combinational slot decode: extracts the slot-select field, checks it against
// the populated-slot mask, and produces the address with the field cleared.
module riscv_sb_decoder #(
  parameter int                    N_SLAVES  = 8,
  parameter int                    SEL_MSB   = 31,
  parameter int                    SEL_LSB   = 24,
  parameter logic [N_SLAVES-1:0]   SLOT_MASK = 8'b1000_1001,
  localparam int                   SW        = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [31:0]   addr,
  output logic [SW-1:0] slot,
  output logic          valid,
  output logic [31:0]   offset
);

  localparam int          FW         = SEL_MSB - SEL_LSB + 1;
  localparam logic [31:0] FIELD_ONES = (FW >= 32) ? '1 : ((32'd1 << FW) - 32'd1);
  localparam logic [31:0] FIELD_MASK = FIELD_ONES << SEL_LSB;

  logic [31:0] field_ext;
  logic        in_range;

  // The range check uses the full zero-extended field, so a wide selector
  // never aliases onto a low slot through truncation.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    field_ext         = '0;
    field_ext[FW-1:0] = addr[SEL_MSB:SEL_LSB];
    in_range          = (field_ext < 32'(N_SLAVES));
    slot              = field_ext[SW-1:0];
    valid             = in_range && SLOT_MASK[slot];
    offset            = addr & ~FIELD_MASK;
  end

endmodule

// File: rtl/riscv_sb_interconnect.sv
// LSU-to-peripheral system-bus interconnect: one transaction at a time through
// an IDLE/ACCESS/RESP FSM, with decode-error and wait-state timeout handling.
module riscv_sb_interconnect
  import riscv_sb_pkg::*;
#(
  parameter int                  N_SLAVES  = 8,
  parameter int                  SEL_MSB   = SB_SEL_MSB,
  parameter int                  SEL_LSB   = SB_SEL_LSB,
  parameter logic [N_SLAVES-1:0] SLOT_MASK = 8'b1000_1001,
  parameter int                  TIMEOUT   = SB_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wd_i,
  output logic [31:0]            rd_o,
  output logic                   ready_o,
  output logic                   err_o,
  output logic [N_SLAVES-1:0]    s_req_o,
  output logic                   s_we_o,
  output logic [3:0]             s_be_o,
  output logic [31:0]            s_addr_o,
  output logic [31:0]            s_wd_o,
  input  logic [32*N_SLAVES-1:0] s_rd_i,
  input  logic [N_SLAVES-1:0]    s_ready_i
);

  localparam int             SW         = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int             CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(TIMEOUT - 1);

  sb_state_t     state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   rd_q, rd_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [SW-1:0] dec_slot;
  logic          dec_valid;
  logic [31:0]   dec_offset;

  riscv_sb_decoder #(
    .N_SLAVES  (N_SLAVES),
    .SEL_MSB   (SEL_MSB),
    .SEL_LSB   (SEL_LSB),
    .SLOT_MASK (SLOT_MASK)
  ) u_decoder (
    .addr   (addr_i),
    .slot   (dec_slot),
    .valid  (dec_valid),
    .offset (dec_offset)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d   = we_i;
          be_d   = be_i;
          addr_d = dec_offset;
          wd_d   = wd_i;
          slot_d = dec_slot;
          cnt_d  = '0;
          if (!dec_valid) begin
            err_d   = 1'b1;
            rd_d    = '0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Ready is checked first so it beats a timeout landing in the same cycle.
        if (s_ready_i[slot_q]) begin
          rd_d    = s_rd_i[{slot_q, 5'b0} +: 32];
          state_d = RESP;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          rd_d    = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (!resetn_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Master and slot outputs depend only on registered state.
  always_comb begin
    s_req_o = '0;
    if (state_q == ACCESS) s_req_o[slot_q] = 1'b1;
  end

  assign ready_o  = (state_q == RESP);
  assign err_o    = ready_o & err_q;
  assign rd_o     = ready_o ? rd_q : '0;
  assign s_we_o   = we_q;
  assign s_be_o   = be_q;
  assign s_addr_o = addr_q;
  assign s_wd_o   = wd_q;

endmodule

// File: tb/tb_riscv_sb_interconnect.sv
// Directed self-checking bench for riscv_sb_interconnect: zero-wait read,
// wait-state write, decode errors, timeout, reset abort and back-to-back reads.
module tb_riscv_sb_interconnect;

  logic         clk_i = 1'b0;
  logic         resetn_i;
  logic         req_i;
  logic         we_i;
  logic [3:0]   be_i;
  logic [31:0]  addr_i;
  logic [31:0]  wd_i;
  logic [31:0]  rd_o;
  logic         ready_o;
  logic         err_o;
  logic [7:0]   s_req_o;
  logic         s_we_o;
  logic [3:0]   s_be_o;
  logic [31:0]  s_addr_o;
  logic [31:0]  s_wd_o;
  logic [255:0] s_rd_i;
  logic [7:0]   s_ready_i;

  int errors = 0;
  int checks = 0;

  riscv_sb_interconnect #(
    .N_SLAVES  (8),
    .SEL_MSB   (31),
    .SEL_LSB   (24),
    .SLOT_MASK (8'b1000_1001),
    .TIMEOUT   (15)
  ) dut (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .addr_i    (addr_i),
    .wd_i      (wd_i),
    .rd_o      (rd_o),
    .ready_o   (ready_o),
    .err_o     (err_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_be_o    (s_be_o),
    .s_addr_o  (s_addr_o),
    .s_wd_o    (s_wd_o),
    .s_rd_i    (s_rd_i),
    .s_ready_i (s_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    resetn_i  = 1'b0;
    req_i     = 1'b0;
    we_i      = 1'b0;
    be_i      = 4'h0;
    addr_i    = '0;
    wd_i      = '0;
    s_ready_i = '0;
    for (int i = 0; i < 8; i++) s_rd_i[32*i +: 32] = 32'h5100_0000 + 32'(i);
    tick();
    tick();
    check("rst_s_req", 32'(s_req_o), 32'h0);
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_rd", rd_o, 32'h0);
    check("rst_s_addr", s_addr_o, 32'h0);
    resetn_i = 1'b1;
    tick();

    // 1: zero-wait read from slot 0
    s_rd_i[31:0] = 32'hDEAD_BEEF;
    s_ready_i    = 8'h01;
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0000_0010;
    tick();
    req_i = 1'b0;
    check("t1_s_req", 32'(s_req_o), 32'h01);
    check("t1_s_addr", s_addr_o, 32'h10);
    check("t1_ready_early", 32'(ready_o), 32'h0);
    tick();
    check("t1_ready", 32'(ready_o), 32'h1);
    check("t1_rd", rd_o, 32'hDEAD_BEEF);
    check("t1_err", 32'(err_o), 32'h0);
    check("t1_s_req_drop", 32'(s_req_o), 32'h0);
    tick();
    check("t1_ready_pulse", 32'(ready_o), 32'h0);

    // 2: write to slot 7 with 3 wait states; slot 0 ready is a distractor
    s_rd_i[255:224] = 32'hCAFE_0007;
    s_ready_i = 8'h01;
    req_i = 1'b1; we_i = 1'b1; be_i = 4'b0011; addr_i = 32'h0700_0004; wd_i = 32'h1234_5678;
    tick();
    req_i = 1'b0;
    check("t2_s_addr", s_addr_o, 32'h4);
    check("t2_s_be", 32'(s_be_o), 32'h3);
    check("t2_s_we", 32'(s_we_o), 32'h1);
    check("t2_s_wd", s_wd_o, 32'h1234_5678);
    for (int c = 1; c <= 3; c++) begin
      check("t2_s_req_wait", 32'(s_req_o), 32'h80);
      check("t2_ready_wait", 32'(ready_o), 32'h0);
      tick();
    end
    s_ready_i = 8'h81;
    check("t2_s_req_last", 32'(s_req_o), 32'h80);
    tick();
    s_ready_i = 8'h00;
    check("t2_ready", 32'(ready_o), 32'h1);
    check("t2_err", 32'(err_o), 32'h0);
    check("t2_rd", rd_o, 32'hCAFE_0007);
    tick();

    // 3: unpopulated slot 2, then out-of-range select 9
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0200_0000;
    tick();
    req_i = 1'b0;
    check("t3a_ready", 32'(ready_o), 32'h1);
    check("t3a_err", 32'(err_o), 32'h1);
    check("t3a_s_req", 32'(s_req_o), 32'h0);
    tick();
    check("t3a_ready_pulse", 32'(ready_o), 32'h0);
    req_i = 1'b1; addr_i = 32'h0900_0000;
    tick();
    req_i = 1'b0;
    check("t3b_ready", 32'(ready_o), 32'h1);
    check("t3b_err", 32'(err_o), 32'h1);
    check("t3b_s_req", 32'(s_req_o), 32'h0);
    tick();

    // 4a: slot 3 never ready -> timeout after 15 ACCESS cycles
    s_rd_i[127:96] = 32'h3333_3333;
    req_i = 1'b1; addr_i = 32'h0300_0000;
    tick();
    req_i = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      check("t4a_s_req", 32'(s_req_o), 32'h08);
      check("t4a_ready_wait", 32'(ready_o), 32'h0);
      tick();
    end
    check("t4a_ready", 32'(ready_o), 32'h1);
    check("t4a_err", 32'(err_o), 32'h1);
    check("t4a_rd", rd_o, 32'h0);
    check("t4a_s_req_drop", 32'(s_req_o), 32'h0);
    tick();

    // 4b: ready on the 15th ACCESS cycle beats the timeout
    req_i = 1'b1; addr_i = 32'h0300_0000;
    tick();
    req_i = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      check("t4b_s_req", 32'(s_req_o), 32'h08);
      if (c == 15) s_ready_i = 8'h08;
      tick();
    end
    s_ready_i = 8'h00;
    check("t4b_ready", 32'(ready_o), 32'h1);
    check("t4b_err", 32'(err_o), 32'h0);
    check("t4b_rd", rd_o, 32'h3333_3333);
    tick();

    // 5: reset mid-ACCESS, then a fresh read
    req_i = 1'b1; we_i = 1'b1; be_i = 4'hC; addr_i = 32'h0300_0040; wd_i = 32'hAAAA_5555;
    tick();
    req_i = 1'b0;
    tick();
    check("t5_s_req_wait", 32'(s_req_o), 32'h08);
    resetn_i = 1'b0;
    tick();
    check("t5_s_req", 32'(s_req_o), 32'h0);
    check("t5_ready", 32'(ready_o), 32'h0);
    check("t5_err", 32'(err_o), 32'h0);
    check("t5_rd", rd_o, 32'h0);
    check("t5_s_we", 32'(s_we_o), 32'h0);
    check("t5_s_be", 32'(s_be_o), 32'h0);
    check("t5_s_addr", s_addr_o, 32'h0);
    check("t5_s_wd", s_wd_o, 32'h0);
    resetn_i = 1'b1;
    tick();
    check("t5_no_resp", 32'(ready_o), 32'h0);
    s_rd_i[31:0] = 32'h0BAD_F00D;
    s_ready_i = 8'h01;
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0000_0020;
    tick();
    req_i = 1'b0;
    check("t5_fresh_s_req", 32'(s_req_o), 32'h01);
    check("t5_fresh_s_addr", s_addr_o, 32'h20);
    tick();
    check("t5_fresh_ready", 32'(ready_o), 32'h1);
    check("t5_fresh_rd", rd_o, 32'h0BAD_F00D);
    tick();

    // 6: back-to-back reads to slots 0 and 7, every slot ready
    for (int i = 0; i < 8; i++) s_rd_i[32*i +: 32] = 32'hB0B0_0000 + 32'(i);
    s_ready_i = 8'hFF;
    req_i = 1'b1; addr_i = 32'h0000_0008;
    tick();
    check("t6_s_req0", 32'(s_req_o), 32'h01);
    tick();
    check("t6_ready0", 32'(ready_o), 32'h1);
    check("t6_rd0", rd_o, 32'hB0B0_0000);
    addr_i = 32'h0700_0008;
    tick();
    check("t6_gap1", 32'(ready_o), 32'h0);
    tick();
    req_i = 1'b0;
    check("t6_s_req7", 32'(s_req_o), 32'h80);
    check("t6_gap2", 32'(ready_o), 32'h0);
    tick();
    check("t6_ready7", 32'(ready_o), 32'h1);
    check("t6_rd7", rd_o, 32'hB0B0_0007);
    check("t6_err7", 32'(err_o), 32'h0);
    s_ready_i = 8'h00;
    tick();
    check("t6_idle", 32'(ready_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
